// File: rtl/pll_lock_clken_seq.sv
// PLL lock supervisor: qualifies the raw lock, releases channel resets in a
// staggered order and generates retunable clock enables. `LOCK_LOSS_CNT_EN adds loss_cnt.
module pll_lock_clken_seq #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 1,
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STAGGER = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock_i,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              div_busy,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic [NUM_CH-1:0] ch_en,
  output logic              locked,
`ifdef LOCK_LOSS_CNT_EN
  output logic [7:0]        loss_cnt,
`endif
  output logic              lock_lost
);

  localparam int REL_LAST = (NUM_CH - 1) * RST_STAGGER;
  localparam int REL_W    = $clog2(REL_LAST + 2);
  localparam int STB_W    = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync;
  logic               lock_s;
  logic               loss_now;
  logic [STB_W-1:0]   stable_cnt;
  logic [REL_W-1:0]   rel_cnt;

  logic [DIV_W-1:0]   cnt     [NUM_CH];
  logic [DIV_W-1:0]   div_reg [NUM_CH];
  logic [NUM_CH-1:0]  term;
  logic [NUM_CH-1:0]  apply;

  logic               pend;
  logic [CH_W-1:0]    wr_ch;
  logic [DIV_W-1:0]   wr_val;

  assign lock_s   = sync[SYNC_STAGES-1];
  assign loss_now = !lock_s && (state == RELEASE || state == RUN);

  // A pending value lands at terminal count, or at once if the channel is held in reset.
  always_comb begin
    term  = '0;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      term[i]  = (cnt[i] == div_reg[i]);
      apply[i] = pend && (int'(wr_ch) == i) && (!ch_rst_n[i] || term[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync       <= '0;
      state      <= WAIT_LOCK;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      ch_rst_n   <= '0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], pll_lock_i};
      lock_lost <= 1'b0;
      if (loss_now) begin
        state      <= WAIT_LOCK;
        stable_cnt <= '0;
        ch_rst_n   <= '0;
        locked     <= 1'b0;
        lock_lost  <= 1'b1;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_s) begin
              state      <= STABLE;
              stable_cnt <= '0;
            end
          end
          // The qualifying cycle in WAIT_LOCK counts as the first of LOCK_STABLE.
          STABLE: begin
            if (!lock_s) begin
              state      <= WAIT_LOCK;
              stable_cnt <= '0;
            end else if (stable_cnt == STB_W'(LOCK_STABLE - 2)) begin
              state   <= RELEASE;
              rel_cnt <= '0;
            end else begin
              stable_cnt <= stable_cnt + STB_W'(1);
            end
          end
          RELEASE: begin
            for (int i = 0; i < NUM_CH; i++)
              if (rel_cnt == REL_W'(i * RST_STAGGER)) ch_rst_n[i] <= 1'b1;
            if (rel_cnt == REL_W'(REL_LAST + 1)) begin
              state  <= RUN;
              locked <= 1'b1;
            end else begin
              rel_cnt <= rel_cnt + REL_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        cnt[i]     <= '0;
        ch_en[i]   <= 1'b0;
        div_reg[i] <= DIV_W'(DIV_DEFAULT);
      end else begin
        ch_en[i] <= ch_rst_n[i] && !loss_now && term[i];
        if (!ch_rst_n[i] || loss_now || term[i]) cnt[i] <= '0;
        else                                     cnt[i] <= cnt[i] + DIV_W'(1);
        if (apply[i]) div_reg[i] <= wr_val;
      end
    end
  end

  // Handshake: busy stays up one cycle past the apply; out-of-range writes never set pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      pend     <= 1'b0;
      wr_ch    <= '0;
      wr_val   <= '0;
    end else if (!div_busy) begin
      if (div_wr) begin
        div_busy <= 1'b1;
        wr_ch    <= div_ch;
        wr_val   <= div_val;
        pend     <= (int'(div_ch) < NUM_CH);
      end
    end else if (pend) begin
      if (|apply) pend <= 1'b0;
    end else begin
      div_busy <= 1'b0;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                             loss_cnt <= '0;
    else if (loss_now && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`endif

endmodule
